// File: rtl/sram_io_host.sv
// Host-side initiator for the SRAM_IO_CTRL serial load/handshake protocol.
// Runs LOAD, EXEC and (for reads) UNLOAD phases and returns a one-cycle response.
module sram_io_host #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
  parameter int TIMEOUT_CYC       = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_we,
  input  logic [MEMORY_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [MEMORY_DATA_WIDTH-1:0] cmd_wdata,
  output logic                         rsp_valid,
  output logic [MEMORY_DATA_WIDTH-1:0] rsp_rdata,
  output logic                         rsp_err,
  output logic                         BGN,
  output logic [1:0]                   CTRL,
  output logic                         LOAD_N,
  output logic                         SI,
  input  logic                         RDY,
  input  logic                         SO
);

  // state       | meaning
  // S_IDLE      | waiting for a command, cmd_ready high
  // S_BGN_ON    | raise BGN for the current phase
  // S_MODE      | drive CTRL with the phase mode
  // S_LOADN     | pull LOAD_N low
  // S_GAP       | one idle cycle before shifting
  // S_SHIFT     | LOAD: shift frame out on SI; UNLOAD: sample SO
  // S_WAIT_RDY  | hold until RDY=1 (timed)
  // S_BGN_OFF   | drop BGN
  // S_LOADN_OFF | release LOAD_N
  // S_WAIT_NRDY | hold until RDY=0 (timed), then next phase or done
  // S_DONE      | successful response pulse
  // S_ERR       | timeout response pulse

  localparam int BW = $clog2(REG_BITS_WIDTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_BGN_ON, S_MODE, S_LOADN, S_GAP, S_SHIFT, S_WAIT_RDY,
    S_BGN_OFF, S_LOADN_OFF, S_WAIT_NRDY, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {PH_LOAD, PH_EXEC, PH_UNLOAD} phase_t;

  state_t                       state, state_d;
  phase_t                       phase, phase_d;
  logic                         we_q;
  logic [REG_BITS_WIDTH-1:0]    shreg;
  logic [MEMORY_DATA_WIDTH-1:0] rdata_q;
  logic [BW-1:0]                bit_cnt;
  logic [TW-1:0]                to_cnt;
  logic                         bgn_q;
  logic                         loadn_q;
  logic [1:0]                   ctrl_q;

  function automatic logic [1:0] mode_of(input phase_t ph, input logic we);
    logic [1:0] m;
    m = 2'b00;
    case (ph)
      PH_EXEC:   m = we ? 2'b11 : 2'b01;
      PH_UNLOAD: m = 2'b10;
      default:   m = 2'b00;
    endcase
    return m;
  endfunction

  always_comb begin
    state_d = state;
    phase_d = phase;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_BGN_ON;
          phase_d = PH_LOAD;
        end
      end
      S_BGN_ON:    state_d = S_MODE;
      S_MODE:      state_d = S_LOADN;
      S_LOADN:     state_d = S_GAP;
      S_GAP:       state_d = (phase == PH_EXEC) ? S_WAIT_RDY : S_SHIFT;
      S_SHIFT:     if (bit_cnt == '0) state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (RDY)                 state_d = S_BGN_OFF;
        else if (to_cnt == '0)   state_d = S_ERR;
      end
      S_BGN_OFF:   state_d = S_LOADN_OFF;
      S_LOADN_OFF: state_d = S_WAIT_NRDY;
      S_WAIT_NRDY: begin
        if (!RDY) begin
          case (phase)
            PH_LOAD: begin
              state_d = S_BGN_ON;
              phase_d = PH_EXEC;
            end
            PH_EXEC: begin
              if (we_q) begin
                state_d = S_DONE;
              end else begin
                state_d = S_BGN_ON;
                phase_d = PH_UNLOAD;
              end
            end
            default: state_d = S_DONE;
          endcase
        end else if (to_cnt == '0) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase   <= PH_LOAD;
      we_q    <= 1'b0;
      shreg   <= '0;
      rdata_q <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      bgn_q   <= 1'b0;
      loadn_q <= 1'b1;
      ctrl_q  <= 2'b00;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      // Pin drivers are decoded from the next state so they line up with it.
      bgn_q   <= state_d inside {S_BGN_ON, S_MODE, S_LOADN, S_GAP, S_SHIFT, S_WAIT_RDY};
      loadn_q <= !(state_d inside {S_LOADN, S_GAP, S_SHIFT, S_WAIT_RDY, S_BGN_OFF});
      if (state_d == S_MODE)
        ctrl_q <= mode_of(phase_d, we_q);
      else if (state_d inside {S_IDLE, S_DONE, S_ERR})
        ctrl_q <= 2'b00;

      if (state == S_IDLE && cmd_valid) begin
        we_q    <= cmd_we;
        shreg   <= {cmd_addr, cmd_we ? cmd_wdata : {MEMORY_DATA_WIDTH{1'b0}}};
        rdata_q <= '0;
      end else if (state == S_SHIFT) begin
        if (phase == PH_LOAD)
          shreg <= shreg >> 1;
        else
          rdata_q <= {SO, rdata_q[MEMORY_DATA_WIDTH-1:1]};
      end

      if (state == S_GAP)
        bit_cnt <= (phase == PH_LOAD) ? BW'(REG_BITS_WIDTH - 1) : BW'(MEMORY_DATA_WIDTH - 1);
      else if (state == S_SHIFT && bit_cnt != '0)
        bit_cnt <= bit_cnt - 1'b1;

      // Timeout down-counter reloads on every entry into a wait state.
      if (state_d != state && state_d inside {S_WAIT_RDY, S_WAIT_NRDY})
        to_cnt <= TW'(TIMEOUT_CYC - 1);
      else if (state inside {S_WAIT_RDY, S_WAIT_NRDY} && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE) || (state == S_ERR);
  assign rsp_err   = (state == S_ERR);
  assign rsp_rdata = (state == S_DONE) ? rdata_q : '0;
  assign BGN       = bgn_q;
  assign LOAD_N    = loadn_q;
  assign CTRL      = ctrl_q;
  assign SI        = (state == S_SHIFT) && (phase == PH_LOAD) && shreg[0];

endmodule

// File: tb/tb_sram_io_host.sv
// Directed bench for sram_io_host with a behavioural SRAM_IO_CTRL responder.
module tb_sram_io_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       BGN, LOAD_N, SI, RDY, SO;
  logic [1:0] CTRL;

  always #5 clk = ~clk;

  sram_io_host dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .BGN(BGN), .CTRL(CTRL), .LOAD_N(LOAD_N), .SI(SI), .RDY(RDY), .SO(SO)
  );

  int checks = 0;
  int failures = 0;
  int rsp_count = 0;

  logic [7:0]  mem [512];
  int          rdy_delay = 0;
  bit          rdy_stuck = 1'b0;
  bit          ok;
  logic [16:0] cap;
  logic [16:0] load_frame = '0;
  logic [7:0]  rd_byte;
  logic [11:0] mode_log = '0;
  int          mode_n = 0;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_count <= rsp_count + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: samples the host pins on the falling edge, aborts on reset.
  task automatic step();
    @(negedge clk);
    if (rst_n !== 1'b1) ok = 1'b0;
  endtask

  task automatic serve_phase();
    logic [1:0] mode;
    mode = CTRL;
    mode_log = {mode_log[9:0], mode};
    mode_n++;
    step();
    if (!ok) return;
    case (mode)
      2'b00: begin
        for (int i = 0; i < 17; i++) begin
          step();
          if (!ok) return;
          cap[i] = SI;
        end
        load_frame = cap;
        for (int i = 0; i < rdy_delay; i++) begin
          step();
          if (!ok) return;
        end
        if (!rdy_stuck) RDY = 1'b1;
      end
      2'b11: begin
        mem[load_frame[16:8]] = load_frame[7:0];
        RDY = 1'b1;
      end
      2'b01: begin
        rd_byte = mem[load_frame[16:8]];
        RDY = 1'b1;
      end
      default: begin
        for (int i = 0; i < 8; i++) begin
          step();
          if (!ok) return;
          SO = rd_byte[i];
        end
        for (int i = 0; i < rdy_delay; i++) begin
          step();
          if (!ok) return;
        end
        RDY = 1'b1;
      end
    endcase
    for (int i = 0; i < 400; i++) begin
      step();
      if (!ok || LOAD_N === 1'b1) break;
    end
    RDY = 1'b0;
    SO = 1'b0;
  endtask

  initial begin : responder
    RDY = 1'b0;
    SO = 1'b0;
    forever begin
      ok = 1'b1;
      RDY = 1'b0;
      SO = 1'b0;
      step();
      if (ok && BGN === 1'b1 && LOAD_N === 1'b0) serve_phase();
    end
  end

  task automatic do_cmd(input logic we, input logic [8:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output logic err, output int lat,
                        output logic b, output logic ln, output logic [1:0] c);
    logic busy_rdy;
    busy_rdy = 1'b0;
    lat = -1; rd = 'x; err = 'x; b = 'x; ln = 'x; c = 'x;
    @(negedge clk);
    chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = i - 1; rd = rsp_rdata; err = rsp_err; b = BGN; ln = LOAD_N; c = CTRL;
        break;
      end
      if (cmd_ready !== 1'b0) busy_rdy = 1'b1;
    end
    chk("ready_low_busy", 32'(busy_rdy), 32'd0);
  endtask

  logic [7:0] rd;
  logic       err, b, ln;
  logic [1:0] c;
  int         lat, cnt0;
  logic [7:0] wr_data [4];

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h021] = 8'hE3;
    for (int i = 0; i < 4; i++) mem[i] = 8'hFF;
    wr_data[0] = 8'h00; wr_data[1] = 8'hAB; wr_data[2] = 8'h3C; wr_data[3] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_pins", 32'({BGN, CTRL, LOAD_N, SI}), 32'b0_00_1_0);
    rst_n = 1'b1;

    // Write 0x020 <- 0x24, RDY two cycles after the last bit.
    rdy_delay = 2; mode_log = '0; mode_n = 0;
    do_cmd(1'b1, 9'h020, 8'h24, rd, err, lat, b, ln, c);
    chk("wr_latency", 32'(lat), 32'd34);
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_rdata", 32'(rd), 32'd0);
    chk("wr_frame_si", 32'(load_frame), 32'h02024);
    chk("wr_modes", 32'(mode_log), 32'h003);
    chk("wr_nphases", 32'(mode_n), 32'd2);
    chk("wr_mem", 32'(mem[9'h020]), 32'h24);
    chk("wr_done_pins", 32'({b, ln, c}), 32'b0_1_00);

    // Read 0x021 -> 0xE3.
    mode_log = '0; mode_n = 0;
    do_cmd(1'b0, 9'h021, 8'h5A, rd, err, lat, b, ln, c);
    chk("rd_latency", 32'(lat), 32'd51);
    chk("rd_err", 32'(err), 32'd0);
    chk("rd_rdata", 32'(rd), 32'hE3);
    chk("rd_frame_si", 32'(load_frame), 32'h02100);
    chk("rd_modes", 32'(mode_log), 32'h006);
    chk("rd_nphases", 32'(mode_n), 32'd3);

    // Back-to-back writes then reads, RDY immediate.
    rdy_delay = 0;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 9'(i), wr_data[i], rd, err, lat, b, ln, c);
      chk("b2b_wr_latency", 32'(lat), 32'd33);
      chk("b2b_wr_err", 32'(err), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, 9'(i), 8'hFF, rd, err, lat, b, ln, c);
      chk("b2b_rd_latency", 32'(lat), 32'd49);
      chk("b2b_rd_data", 32'(rd), 32'(wr_data[i]));
    end

    // RDY stuck low in LOAD WAIT_RDY: entered 21 cycles after accept, error 64 later.
    rdy_stuck = 1'b1;
    do_cmd(1'b1, 9'h010, 8'h77, rd, err, lat, b, ln, c);
    chk("to_latency", 32'(lat), 32'd85);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", 32'(rd), 32'd0);
    chk("to_pins", 32'({b, ln, c}), 32'b0_1_00);
    chk("to_no_exec", 32'(mem[9'h010]), 32'd0);
    rdy_stuck = 1'b0;

    // Reset during the 10th SHIFT cycle.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 9'h0A0; cmd_wdata = 8'h55;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("mid_shift_active", 32'({BGN, LOAD_N}), 32'b10);
    cnt0 = rsp_count;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("arst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("arst_pins", 32'({BGN, CTRL, LOAD_N, SI}), 32'b0_00_1_0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_rsp", 32'(rsp_count - cnt0), 32'd0);
    chk("arst_no_exec", 32'(mem[9'h0A0]), 32'd0);
    do_cmd(1'b1, 9'h0A0, 8'h55, rd, err, lat, b, ln, c);
    chk("post_rst_wr_latency", 32'(lat), 32'd33);
    do_cmd(1'b0, 9'h0A0, 8'h00, rd, err, lat, b, ln, c);
    chk("post_rst_rd_data", 32'(rd), 32'h55);
    chk("post_rst_rd_err", 32'(err), 32'd0);

    // cmd_valid held high while busy with a different address.
    mode_n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 9'h005; cmd_wdata = 8'h5A;
    @(posedge clk);
    #1 cmd_addr = 9'h006; cmd_wdata = 8'h6B;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = i - 1; break; end
    end
    chk("busy_a_latency", 32'(lat), 32'd33);
    chk("busy_a_frame", 32'(load_frame), 32'h0055A);
    chk("busy_a_only_one", 32'(mode_n), 32'd2);
    @(negedge clk);
    chk("busy_idle_after_rsp", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_b_accepted", 32'(cmd_ready), 32'd0);
    lat = -1;
    for (int i = 2; i <= 300; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = i - 1; break; end
    end
    chk("busy_b_latency", 32'(lat), 32'd33);
    chk("busy_b_frame", 32'(load_frame), 32'h0066B);
    chk("busy_mem_a", 32'(mem[9'h005]), 32'h5A);
    chk("busy_mem_b", 32'(mem[9'h006]), 32'h6B);
    chk("busy_nphases", 32'(mode_n), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_io_host.md
Name: sram_io_host

Overview:
- Host-side initiator for the SRAM_IO_CTRL serial load/handshake protocol; replaces the FPGA/C-code polling sequence with hardware.
- Accepts one parallel SRAM command (write byte / read byte) and generates BGN, CTRL, LOAD_N and SI toward SRAM_IO_CTRL.
- Polls RDY at each phase; for reads, collects the data byte from SO.
- Returns a single-cycle response pulse to the requesting logic (boot loader or debug port).

Parameters:
- MEMORY_DATA_WIDTH, 8, SRAM data width.
- MEMORY_ADDR_WIDTH, 9, SRAM address width.
- REG_BITS_WIDTH, MEMORY_ADDR_WIDTH+MEMORY_DATA_WIDTH, serial frame length.
- TIMEOUT_CYC, 64, maximum cycles spent waiting for any single RDY edge.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  MEMORY_ADDR_WIDTH  SRAM address.
- cmd_wdata  in  MEMORY_DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  MEMORY_DATA_WIDTH  read data; valid with rsp_valid; 0 after writes.
- rsp_err  out  1  timeout flag; valid with rsp_valid.
- BGN  out  1  to SRAM_IO_CTRL BGN.
- CTRL  out  2  to SRAM_IO_CTRL CTRL.
- LOAD_N  out  1  to SRAM_IO_CTRL LOAD_N.
- SI  out  1  serial data to SRAM_IO_CTRL.
- RDY  in  1  from SRAM_IO_CTRL.
- SO  in  1  serial data from SRAM_IO_CTRL.

Behaviour:
- Reset values (asynchronous):
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - BGN=0, CTRL=2'b00, LOAD_N=1, SI=0.
  - FSM in IDLE; shift register, bit counter and timeout counter cleared.
- Reset asserted mid-operation aborts immediately to these values. No response is issued.
- Accept: the command is latched and frame = {cmd_addr, cmd_we ? cmd_wdata : 0} is formed.
- Every transaction runs phases in order:
  - LOAD (CTRL=00).
  - then EXEC (CTRL=11 for a write, 01 for a read).
  - then, for reads only, UNLOAD (CTRL=10).
- Each phase follows this sequence, one state per cycle unless noted:
  - BGN_ON: BGN=1.
  - MODE: CTRL=phase mode.
  - LOADN: LOAD_N=0.
  - GAP: one idle cycle.
  - SHIFT:
    - LOAD phase: drive SI=frame[0] and shift right each cycle, for exactly REG_BITS_WIDTH cycles (LSB first, data bits then address bits).
    - UNLOAD phase: sample SO on MEMORY_DATA_WIDTH consecutive cycles, LSB first, into rsp_rdata's shadow.
    - EXEC phase: skips SHIFT.
  - WAIT_RDY: hold until RDY=1.
  - BGN_OFF: BGN=0.
  - LOADN_OFF: LOAD_N=1.
  - WAIT_NRDY: hold until RDY=0, then advance to the next phase, or DONE.
- DONE:
  - rsp_valid=1 for one cycle with rsp_err=0; rsp_rdata updated (read) or 0 (write).
  - CTRL returns to 00; FSM returns to IDLE; cmd_ready high the next cycle.
- SI holds 0 outside SHIFT. CTRL holds its phase value until the next phase's MODE state.
- Timeout:
  - The counter clears on entry to WAIT_RDY or WAIT_NRDY and increments each cycle spent there.
  - On reaching TIMEOUT_CYC: BGN=0, LOAD_N=1, CTRL=00, rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE.
- RDY already at the awaited level on entry to a wait state: advance on the next cycle (minimum one cycle in each wait state).
- cmd_valid while busy: ignored; the command is not latched.
- Back-to-back commands: a new command may be accepted the cycle after rsp_valid.
- Minimum write latency (RDY immediate): (4+17+4) + (4+4) = 33 cycles accept-to-rsp_valid.

Test Plan:
- Write addr 0x020, data 0x24, with a model that raises RDY 2 cycles after the last expected bit → SI shows 0,0,1,0,0,1,0,0 then 0,0,0,0,0,1,0,0,0; CTRL sequence 00→11; rsp_valid=1, rsp_err=0.
- Read addr 0x021 after the write above, with model SO stream 0xE3 LSB first → frame data bits all 0; CTRL 00→01→10; rsp_rdata=0xE3.
- Write data 0x00AB/0x3C00 bytes to addrs 0x000–0x003 back-to-back, then read all four → read data matches exactly; cmd_ready low throughout each transaction.
- RDY stuck 0 in LOAD WAIT_RDY → rsp_valid with rsp_err=1 exactly 64 cycles after entering the wait; BGN=0, LOAD_N=1 the same cycle.
- rst_n pulsed low during the 10th SHIFT cycle → all outputs at reset values immediately; no rsp_valid; the next command completes normally.
- cmd_valid held high with differing addr during a busy period → only the first command executes; the second is accepted only after rsp_valid.
